vga_timing_gen: RTL

//  Generates 640x480@60Hz VGA raster timing from the 100 MHz board clock. Drives hCount/vCount/bright

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60Hz raster timing constants
// and a counter-width helper shared by the timing blocks.
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;

    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 514;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-N raster axis counter with a
// wrap strobe and sync/visible decode registered with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int N         = H_TOTAL,
    parameter int SYNC      = H_SYNC,
    parameter int VIS_START = H_VIS_START,
    parameter int VIS_END   = H_VIS_END
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               last,
    output logic               wrap,
    output logic               sync,
    output logic               vis
);

    localparam logic [COUNT_W-1:0] LAST_C = COUNT_W'(N - 1);
    localparam logic [COUNT_W-1:0] SYNC_C = COUNT_W'(SYNC);
    localparam logic [COUNT_W-1:0] VS_C   = COUNT_W'(VIS_START);
    localparam logic [COUNT_W-1:0] VE_C   = COUNT_W'(VIS_END);

    logic [COUNT_W-1:0] nxt;

    // next position along the axis, wrapping at N-1
    always_comb begin
        nxt = (count == LAST_C) ? '0 : count + 1'b1;
    end

    assign wrap = en && last;

    // decode the value being loaded so flags line up with the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            last  <= 1'b0;
            sync  <= 1'b0;
            vis   <= 1'b0;
        end else if (en) begin
            count <= nxt;
            last  <= (nxt == LAST_C);
            sync  <= (nxt >= SYNC_C);
            vis   <= (nxt >= VS_C) && (nxt <= VE_C);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing, pixel strobe and game move tick.
// VGA_SYNC_PIPE_EN: hSync/vSync/bright delayed one pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END,
    parameter int MOVE_DIV    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               bright,
    output logic               hSync,
    output logic               vSync,
    output logic               pix_tick,
    output logic               frame_tick,
    output logic               move_tick
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int FRM_W = cnt_w(MOVE_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(MOVE_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [FRM_W-1:0] frm;
    logic             h_last, h_wrap, h_sync, h_vis;
    logic             v_last, v_wrap, v_sync, v_vis;
    logic             frame_pre;

    // board clock to pixel clock divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div <= '0;
        else      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    assign pix_tick = (div == DIV_LAST);

    vga_axis_counter #(
        .N(H_TOTAL), .SYNC(H_SYNC),
        .VIS_START(H_VIS_START), .VIS_END(H_VIS_END)
    ) u_h (
        .clk(clk), .rst(rst), .en(pix_tick),
        .count(hCount), .last(h_last), .wrap(h_wrap),
        .sync(h_sync), .vis(h_vis)
    );

    vga_axis_counter #(
        .N(V_TOTAL), .SYNC(V_SYNC),
        .VIS_START(V_VIS_START), .VIS_END(V_VIS_END)
    ) u_v (
        .clk(clk), .rst(rst), .en(h_wrap),
        .count(vCount), .last(v_last), .wrap(v_wrap),
        .sync(v_sync), .vis(v_vis)
    );

    // one cycle ahead of the last-pixel strobe, so ticks are registered
    assign frame_pre = (div == DIV_PRE) && h_last && v_last;

    // frame and move pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
            move_tick  <= 1'b0;
        end else begin
            frame_tick <= frame_pre;
            move_tick  <= frame_pre && (frm == FRM_LAST);
        end
    end

    // frames since last move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        frm <= '0;
        else if (v_wrap) frm <= (frm == FRM_LAST) ? '0 : frm + 1'b1;
    end

`ifdef VGA_SYNC_PIPE_EN
    // one-pixel delay to match a registered rgb downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else if (pix_tick) begin
            hSync  <= h_sync;
            vSync  <= v_sync;
            bright <= h_vis && v_vis;
        end
    end
`else
    assign hSync  = h_sync;
    assign vSync  = v_sync;
    assign bright = h_vis && v_vis;
`endif

endmodule
